// File: rtl/rxd_pkg.sv
// Shared definitions for the buffered serial receiver: FSM encoding,
// oversampling ratio and the baud divisor helper.
package rxd_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  // Rounded clock cycles per oversample tick.
  function automatic int rxd_div(input int clk_hz, input int baud);
    return (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/rxd_fifo_receiver_if.sv
// Host-side signal bundle of the buffered serial receiver.
interface rxd_fifo_receiver_if #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16
);
  logic                   SDI;
  logic                   ReadEnable;
  logic                   ClearData;
  logic [DATA_BITS-1:0]   ReadData;
  logic                   DataAvailable;
  logic [$clog2(DEPTH):0] Count;
  logic                   Overrun;
  logic                   FramingError;

  modport slave (
    input  SDI, ReadEnable, ClearData,
    output ReadData, DataAvailable, Count, Overrun, FramingError
  );

  modport master (
    output SDI, ReadEnable, ClearData,
    input  ReadData, DataAvailable, Count, Overrun, FramingError
  );
endinterface

// File: rtl/rxd_deserializer.sv
// Oversampling UART receiver: synchroniser, tick generator, frame FSM and
// shift register. Emits one-cycle push / framing-error strobes.
module rxd_deserializer
  import rxd_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sdi,
  output logic [DATA_BITS-1:0] word,
  output logic                 push,
  output logic                 frame_err
);
  localparam int DIV_RAW = rxd_div(CLK_HZ, BAUD);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TICK_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W   = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [TICK_W-1:0] MID_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] END_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic                 sdi_meta_q, sdi_sync_q, sdi_prev_q;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sdi_meta_q <= 1'b1;
      sdi_sync_q <= 1'b1;
      sdi_prev_q <= 1'b1;
      div_cnt_q  <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sdi_meta_q <= sdi;
      sdi_sync_q <= sdi_meta_q;
      sdi_prev_q <= sdi_sync_q;
      div_cnt_q  <= div_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = '0;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    push       = 1'b0;
    frame_err  = 1'b0;
    tick       = (state_q != IDLE) && (div_cnt_q == DIV_LAST);

    // Divider runs only while a frame is in progress, so it restarts on each start edge.
    if ((state_q != IDLE) && !tick) div_cnt_d = div_cnt_q + 1'b1;
    if (tick) tick_cnt_d = tick_cnt_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        if (sdi_prev_q && !sdi_sync_q) state_d = START;
      end
      START: begin
        if (tick && (tick_cnt_q == MID_TICK)) begin
          tick_cnt_d = '0;
          state_d    = sdi_sync_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick && (tick_cnt_q == END_TICK)) begin
          shift_d   = {sdi_sync_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) state_d = STOP;
        end
      end
      STOP: begin
        if (tick && (tick_cnt_q == END_TICK)) begin
          if (sdi_sync_q) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (sdi_sync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign word = shift_q;

endmodule

// File: rtl/rxd_fifo_receiver.sv
// Serial receiver feeding a first-word-fall-through FIFO with a registered
// head word, explicit fill count and sticky overrun / framing flags.
module rxd_fifo_receiver
  import rxd_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16
) (
  input logic                Clock,
  input logic                Reset,
  rxd_fifo_receiver_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [DATA_BITS-1:0] word;
  logic                 push, frame_err;

  rxd_deserializer #(
    .CLK_HZ   (CLK_HZ),
    .BAUD     (BAUD),
    .DATA_BITS(DATA_BITS)
  ) u_deser (
    .clk      (Clock),
    .rst      (Reset),
    .sdi      (bus.SDI),
    .word     (word),
    .push     (push),
    .frame_err(frame_err)
  );

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic                 overrun_q, overrun_d, ferr_q, ferr_d;
  logic                 empty, full, do_pop, do_push, do_write;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rdata_q   <= '0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rdata_q   <= rdata_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (do_write) mem_q[wr_ptr_q] <= word;
  end

  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == FULL_CNT);
    do_pop    = bus.ReadEnable && !empty;
    do_push   = push && (!full || do_pop);
    do_write  = do_push && !bus.ClearData;
    rd_next   = rd_ptr_q + 1'b1;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rdata_d   = rdata_q;
    overrun_d = overrun_q;
    ferr_d    = ferr_q;

    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_next;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (do_pop && !do_push) count_d = count_q - 1'b1;
    if (push && full && !do_pop) overrun_d = 1'b1;
    if (frame_err) ferr_d = 1'b1;

    // Head register: the word behind the popped one, or the incoming word when it becomes the head.
    if (do_pop) begin
      if (count_q > ONE_CNT) rdata_d = mem_q[rd_next];
      else if (do_push)      rdata_d = word;
    end else if (do_push && empty) begin
      rdata_d = word;
    end

    if (bus.ClearData) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      overrun_d = 1'b0;
      ferr_d    = 1'b0;
    end
  end

  assign bus.ReadData      = rdata_q;
  assign bus.DataAvailable = !empty;
  assign bus.Count         = count_q;
  assign bus.Overrun       = overrun_q;
  assign bus.FramingError  = ferr_q;

endmodule

// File: doc/rxd_fifo_receiver.md
# rxd_fifo_receiver

Parametrised serial receive block: an on-chip UART deserialiser feeding a first-word-fall-through FIFO. It sits between the host serial line (SDI) and the command decoder. It replaces single-byte capture with buffered capture of configurable depth and width. A received value of zero is a valid entry. Overrun and framing errors are reported.

## Interface
- CLK_HZ, 50_000_000, system clock frequency in Hz
- BAUD, 115200, serial bit rate
- DATA_BITS, 8, data bits per frame (5–9), LSB first
- DEPTH, 16, FIFO entries; power of two, ≥2
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- SDI  in  1  serial input, idle high, asynchronous to Clock
- ReadEnable  in  1  pop head entry; ignored when empty
- ClearData  in  1  synchronous flush: empties FIFO, clears Overrun and FramingError
- ReadData  out  DATA_BITS  head entry; valid while DataAvailable=1
- DataAvailable  out  1  FIFO not empty
- Count  out  $clog2(DEPTH)+1  entries held, 0..DEPTH
- Overrun  out  1  sticky: a byte was dropped because the FIFO was full
- FramingError  out  1  sticky: stop bit sampled low

## Operation
- SDI passes through a 2-flop synchroniser. Both flops reset to 1.
- A tick generator pulses every DIV = round(CLK_HZ/(BAUD*16)) cycles, giving 16 ticks per bit. The tick counter is held at 0 in IDLE and restarts on start-edge detection.
- Receiver FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: a synchronised falling edge on SDI moves to START.
  - START: after 8 ticks (mid-bit), SDI low moves to DATA. SDI high is a glitch and returns to IDLE.
  - DATA: 16 ticks per bit. Sample into a shift register LSB first. After DATA_BITS samples, move to STOP.
  - STOP: sample at 16 ticks. High: push the word and go to IDLE. Low: set FramingError, discard the word, go to WAIT_IDLE.
  - WAIT_IDLE: stay until synchronised SDI is high, then go to IDLE.
- FIFO: circular buffer. Pointers are $clog2(DEPTH) bits and wrap naturally. Count is maintained explicitly.
  - Push when full and no simultaneous pop: the word is dropped, Overrun is set, and contents are unchanged.
  - Push and pop in the same cycle, any fill level except empty: both take effect and Count is unchanged. When full, this does not set Overrun.
  - Pop when empty: no effect, and Count does not underflow.
- ClearData has priority over push and pop in the same cycle. The pushed word is lost and Overrun is not set. ClearData does not affect the receiver FSM; a frame in progress completes and is pushed normally.
- Reset, at any point including mid-frame:
  - FSM goes to IDLE; pointers, Count, Overrun and FramingError go to 0.
  - ReadData=0 and DataAvailable=0.

## Timing
- Push strobe: one cycle, at the clock edge following the stop-bit mid-sample.
- DataAvailable, Count and ReadData update at the same edge as the push. Latency from SDI stop-bit midpoint to DataAvailable is 2 synchroniser cycles plus 1 cycle.
- ReadData is registered. After a pop, the next entry (or a held value if the FIFO becomes empty) appears one cycle later. DataAvailable falls in that same cycle when the last entry is popped.
- ReadEnable may be held high for back-to-back pops, one entry per cycle.
- Overrun and FramingError assert in the cycle after the offending event. They clear only on ClearData or Reset.

## Structure
- Shared package rxd_pkg holds:
  - receiver state encoding (IDLE..WAIT_IDLE)
  - the OVERSAMPLE=16 constant
  - the divisor function computing DIV from CLK_HZ and BAUD
- Sub-module rxd_deserializer holds the synchroniser, tick generator, FSM and shift register. It outputs a word, a push strobe and a framing-error strobe.
- The top level holds the FIFO storage, pointers, Count and sticky flags.

## Test plan
- CLK_HZ=16×BAUD×4 (DIV=4), DATA_BITS=8: send 0x00, then 0xA5 → two entries, ReadData=0x00 and DataAvailable=1 first, then 0xA5 after one pop; Count goes 2→1→0.
- 1-tick low glitch on idle SDI → no push, FSM back in IDLE, Count=0, FramingError=0.
- Frame 0x3C with stop bit forced low → FramingError=1, Count=0. Then a valid frame 0x55 → Count=1, ReadData=0x55.
- DEPTH=4: send 5 frames 0x01..0x05 with no reads → Count=4, Overrun=1, pops yield 0x01..0x04. Repeat with ReadEnable pulsed exactly on the 5th push cycle → Overrun=0, Count=4, head=0x02.
- Fill to 3 entries, assert ClearData in the push cycle of a 4th → Count=0, DataAvailable=0, flags 0. Next frame 0x7E is received normally.
- Assert Reset mid-DATA of a frame → all outputs 0 in the same cycle. After release, a clean frame 0x81 → Count=1, ReadData=0x81.
